// File: rtl/ex_md_if.sv
// EX-stage bundle between ID/EX, forwarding unit and the EX/MD datapath.
interface ex_md_if #(
  parameter int DATA_W = 32
);
  logic [31:0]       id_ex_instr;
  logic              ex_valid;
  logic [DATA_W-1:0] reg1;
  logic [DATA_W-1:0] reg2;
  logic [DATA_W-1:0] id_ex_imm_value;
  logic [DATA_W-1:0] ex_mem_alu_result;
  logic [DATA_W-1:0] mem_wb_write_back_result;
  logic              id_ex_alu_src;
  logic [1:0]        id_ex_alu_op;
  logic [1:0]        Forward_A;
  logic [1:0]        Forward_B;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] alu_in2_out;
  logic [DATA_W-1:0] hi_out;
  logic [DATA_W-1:0] lo_out;
  logic              zero;
  logic              stall;
  logic              md_busy;

  modport master (
    output id_ex_instr, ex_valid, reg1, reg2, id_ex_imm_value,
    output ex_mem_alu_result, mem_wb_write_back_result,
    output id_ex_alu_src, id_ex_alu_op, Forward_A, Forward_B,
    input  alu_result, alu_in2_out, hi_out, lo_out,
    input  zero, stall, md_busy
  );

  modport slave (
    input  id_ex_instr, ex_valid, reg1, reg2, id_ex_imm_value,
    input  ex_mem_alu_result, mem_wb_write_back_result,
    input  id_ex_alu_src, id_ex_alu_op, Forward_A, Forward_B,
    output alu_result, alu_in2_out, hi_out, lo_out,
    output zero, stall, md_busy
  );
endinterface

// File: rtl/ex_md_pipe_stage.sv
// EX stage: forwarding muxes, ALU and an iterative multiply/divide unit.
// Define EX_MD_DIV_EN to build the divider (DIV/DIVU).
module ex_md_pipe_stage #(
  parameter int DATA_W = 32
) (
  input logic    clk,
  input logic    reset,
  ex_md_if.slave bus
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [CW-1:0] CNT_LD = CW'(DATA_W);

  logic [0:0]        state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] acc_hi, acc_lo, mag_b;
  logic [DATA_W-1:0] hi_r, lo_r;
  logic              sa, sb;

  logic [5:0]        funct;
  logic [DATA_W-1:0] op_a, op_b, alu_b, alu_res;
  logic [DATA_W-1:0] mag_a_in, mag_b_in;
  logic              r_type, is_mul, is_div, is_mf, is_md;
  logic              md_sgn, a_neg, b_neg, accept;
  logic              unused;

  assign funct  = bus.id_ex_instr[5:0];
  assign unused = ^bus.id_ex_instr[31:6];

  always_comb begin
    unique case (bus.Forward_A)
      2'b01:   op_a = bus.mem_wb_write_back_result;
      2'b10:   op_a = bus.ex_mem_alu_result;
      default: op_a = bus.reg1;
    endcase
  end

  always_comb begin
    unique case (bus.Forward_B)
      2'b01:   op_b = bus.mem_wb_write_back_result;
      2'b10:   op_b = bus.ex_mem_alu_result;
      default: op_b = bus.reg2;
    endcase
  end

  assign alu_b = bus.id_ex_alu_src ? bus.id_ex_imm_value : op_b;

  always_comb begin
    alu_res = '0;
    unique case (bus.id_ex_alu_op)
      2'b00: alu_res = op_a + alu_b;
      2'b01: alu_res = op_a - alu_b;
      2'b10: begin
        unique case (funct)
          6'h20:   alu_res = op_a + alu_b;
          6'h22:   alu_res = op_a - alu_b;
          6'h24:   alu_res = op_a & alu_b;
          6'h25:   alu_res = op_a | alu_b;
          6'h27:   alu_res = ~(op_a | alu_b);
          6'h2A:   alu_res = {{(DATA_W-1){1'b0}},
                              $signed(op_a) < $signed(alu_b)};
          6'h10:   alu_res = hi_r;
          6'h12:   alu_res = lo_r;
          default: alu_res = '0;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

  assign r_type = bus.id_ex_alu_op == 2'b10;
  assign is_mul = r_type & (funct == 6'h18 | funct == 6'h19);
`ifdef EX_MD_DIV_EN
  assign is_div = r_type & (funct == 6'h1A | funct == 6'h1B);
`else
  assign is_div = 1'b0;
`endif
  assign is_mf  = r_type & (funct == 6'h10 | funct == 6'h12);
  assign is_md  = is_mul | is_div;
  // Even functs (MULT, DIV) are the signed variants.
  assign md_sgn = ~funct[0];
  assign a_neg  = md_sgn & op_a[DATA_W-1];
  assign b_neg  = md_sgn & op_b[DATA_W-1];
  assign mag_a_in = a_neg ? -op_a : op_a;
  assign mag_b_in = b_neg ? -op_b : op_b;
  assign accept = bus.ex_valid & is_md & (state == IDLE);

  logic [DATA_W:0]     m_sum;
  logic [DATA_W-1:0]   nx_hi, nx_lo, fin_hi, fin_lo;
  logic [2*DATA_W-1:0] prod;

  assign m_sum = {1'b0, acc_hi}
               + (acc_lo[0] ? {1'b0, mag_b} : {(DATA_W+1){1'b0}});

`ifdef EX_MD_DIV_EN
  logic              op_div, dz;
  logic [DATA_W+1:0] d_diff;

  assign d_diff = {1'b0, acc_hi, acc_lo[DATA_W-1]} - {2'b00, mag_b};

  always_ff @(posedge clk) begin
    if (reset) begin
      op_div <= 1'b0;
      dz     <= 1'b0;
    end else if (accept) begin
      op_div <= is_div;
      dz     <= ~|op_b;
    end
  end
`endif

  always_comb begin
    nx_hi = m_sum[DATA_W:1];
    nx_lo = {m_sum[0], acc_lo[DATA_W-1:1]};
`ifdef EX_MD_DIV_EN
    // Restoring step: remainder in acc_hi, quotient shifts into acc_lo.
    if (op_div) begin
      nx_hi = d_diff[DATA_W+1] ? {acc_hi[DATA_W-2:0], acc_lo[DATA_W-1]}
                               : d_diff[DATA_W-1:0];
      nx_lo = {acc_lo[DATA_W-2:0], ~d_diff[DATA_W+1]};
    end
`endif
  end

  assign prod = {nx_hi, nx_lo};

  always_comb begin
    {fin_hi, fin_lo} = (sa ^ sb) ? -prod : prod;
`ifdef EX_MD_DIV_EN
    if (op_div) begin
      fin_lo = dz ? '1 : ((sa ^ sb) ? -nx_lo : nx_lo);
      fin_hi = sa ? -nx_hi : nx_hi;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      mag_b  <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else if (state == IDLE) begin
      if (accept) begin
        state  <= BUSY;
        cnt    <= CNT_LD;
        acc_hi <= '0;
        acc_lo <= mag_a_in;
        mag_b  <= mag_b_in;
        sa     <= a_neg;
        sb     <= b_neg;
      end
    end else begin
      acc_hi <= nx_hi;
      acc_lo <= nx_lo;
      cnt    <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        state <= IDLE;
        hi_r  <= fin_hi;
        lo_r  <= fin_lo;
      end
    end
  end

  assign bus.alu_result  = alu_res;
  assign bus.alu_in2_out = op_b;
  assign bus.zero        = alu_res == '0;
  assign bus.hi_out      = hi_r;
  assign bus.lo_out      = lo_r;
  assign bus.md_busy     = state == BUSY;
  assign bus.stall       = bus.ex_valid & (state == BUSY) & (is_md | is_mf);
endmodule

// File: tb/tb_ex_md_pipe_stage.sv
// Scoreboarded bench for ex_md_pipe_stage: ALU/forwarding table,
// multiply/divide results, stall behaviour and reset abort.
module tb_ex_md_pipe_stage;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] sb_q[$];

  ex_md_if #(.DATA_W(W)) bus ();

  ex_md_pipe_stage #(.DATA_W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.ex_valid                 = 1'b0;
    bus.id_ex_instr              = '0;
    bus.id_ex_alu_op             = 2'b00;
    bus.id_ex_alu_src            = 1'b0;
    bus.Forward_A                = 2'b00;
    bus.Forward_B                = 2'b00;
    bus.reg1                     = $urandom;
    bus.reg2                     = $urandom;
    bus.id_ex_imm_value          = $urandom;
    bus.ex_mem_alu_result        = $urandom;
    bus.mem_wb_write_back_result = $urandom;
  endtask

  task automatic alu_case(input string tag, input logic [1:0] op,
                          input logic [5:0] f, input logic [1:0] fa,
                          input logic [1:0] fb, input logic src,
                          input logic [31:0] r1, input logic [31:0] r2,
                          input logic [31:0] imm, input logic [31:0] exm,
                          input logic [31:0] mwb, input logic [31:0] exp,
                          input logic [31:0] exp2);
    @(negedge clk);
    bus.ex_valid                 = 1'b1;
    bus.id_ex_alu_op             = op;
    bus.id_ex_instr              = {26'h0, f};
    bus.Forward_A                = fa;
    bus.Forward_B                = fb;
    bus.id_ex_alu_src            = src;
    bus.reg1                     = r1;
    bus.reg2                     = r2;
    bus.id_ex_imm_value          = imm;
    bus.ex_mem_alu_result        = exm;
    bus.mem_wb_write_back_result = mwb;
    #1;
    chk({tag, "_res"}, bus.alu_result, exp);
    chk({tag, "_zero"}, bus.zero, exp == 32'h0);
    chk({tag, "_in2"}, bus.alu_in2_out, exp2);
  endtask

  task automatic drive_md(input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b);
    bus.ex_valid          = 1'b1;
    bus.id_ex_alu_op      = 2'b10;
    bus.id_ex_alu_src     = 1'b0;
    bus.id_ex_instr       = {26'h0, f};
    bus.Forward_A         = 2'b10;
    bus.ex_mem_alu_result = a;
    bus.reg1              = ~a;
    bus.Forward_B         = 2'b00;
    bus.reg2              = b;
  endtask

  task automatic wait_md(input string tag);
    int n = 0;
    logic [63:0] e;
    while (bus.md_busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_cycles"}, n, 32);
    if (sb_q.size() == 0) begin
      chk({tag, "_sbempty"}, 1, 0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_hilo"}, {bus.hi_out, bus.lo_out}, e);
    end
  endtask

  task automatic md_op(input string tag, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp);
    @(negedge clk);
    drive_md(f, a, b);
    sb_q.push_back(exp);
    #1 chk({tag, "_stall0"}, bus.stall, 0);
    @(negedge clk);
    idle();
    chk({tag, "_busy"}, bus.md_busy, 1);
    wait_md(tag);
  endtask

  initial begin
    int n;
    logic [63:0] e;
    logic [31:0] ra, rb;
    longint sa, sb;

    reset = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.md_busy, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_hi", bus.hi_out, 0);
    chk("rst_lo", bus.lo_out, 0);
    reset = 1'b0;

    alu_case("add_fwd", 2'b10, 6'h20, 2'b10, 2'b00, 1'b0,
             32'h1, 32'h7, 32'h0, 32'h5, 32'h9, 32'd12, 32'h7);
    alu_case("fb11", 2'b10, 6'h20, 2'b00, 2'b11, 1'b0,
             32'h3, 32'h7, 32'h0, 32'h50, 32'h90, 32'd10, 32'h7);
    alu_case("sub_mwb", 2'b01, 6'h00, 2'b01, 2'b00, 1'b0,
             32'h1, 32'h9, 32'h0, 32'h5, 32'h9, 32'h0, 32'h9);
    alu_case("and", 2'b10, 6'h24, 2'b00, 2'b00, 1'b0,
             32'hF0F0, 32'hFF00, 32'h0, 32'h0, 32'h0, 32'hF000, 32'hFF00);
    alu_case("or", 2'b10, 6'h25, 2'b00, 2'b00, 1'b0,
             32'hF0F0, 32'hFF00, 32'h0, 32'h0, 32'h0, 32'hFFF0, 32'hFF00);
    alu_case("nor", 2'b10, 6'h27, 2'b00, 2'b00, 1'b0,
             32'hF0F0, 32'hFF00, 32'h0, 32'h0, 32'h0, 32'hFFFF000F, 32'hFF00);
    alu_case("slt_t", 2'b10, 6'h2A, 2'b00, 2'b00, 1'b0,
             32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 32'h0, 32'h1, 32'h1);
    alu_case("slt_f", 2'b10, 6'h2A, 2'b00, 2'b00, 1'b0,
             32'h1, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF);
    alu_case("imm", 2'b00, 6'h00, 2'b00, 2'b00, 1'b1,
             32'd10, 32'd100, 32'hFFFFFFFF, 32'h0, 32'h0, 32'd9, 32'd100);
    alu_case("op11", 2'b11, 6'h20, 2'b00, 2'b00, 1'b0,
             32'h3, 32'h4, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4);
    alu_case("badf", 2'b10, 6'h3F, 2'b00, 2'b00, 1'b0,
             32'h3, 32'h4, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4);
    alu_case("sub_fb10", 2'b10, 6'h22, 2'b01, 2'b10, 1'b0,
             32'h1, 32'h2, 32'h0, 32'h4, 32'd20, 32'd16, 32'h4);
    @(negedge clk);
    idle();

    md_op("mult", 6'h18, 32'hFFFFFFFE, 32'h3, 64'hFFFFFFFF_FFFFFFFA);
    md_op("multu", 6'h19, 32'hFFFFFFFE, 32'h3, 64'h00000002_FFFFFFFA);

    @(negedge clk);
    bus.ex_valid     = 1'b1;
    bus.id_ex_alu_op = 2'b10;
    bus.id_ex_instr  = {26'h0, 6'h10};
    #1;
    chk("mfhi_stall", bus.stall, 0);
    chk("mfhi_val", bus.alu_result, 32'h2);
    @(negedge clk);
    idle();

    for (int i = 0; i < 3; i++) begin
      ra = $urandom;
      rb = $urandom;
      sa = longint'($signed(ra));
      sb = longint'($signed(rb));
      md_op("rmultu", 6'h19, ra, rb, {32'h0, ra} * {32'h0, rb});
      md_op("rmult", 6'h18, ra, rb, 64'(sa * sb));
    end

    // MFLO waits behind a running MULT; ADD flows through.
    @(negedge clk);
    drive_md(6'h18, 32'h1234, 32'h10);
    sb_q.push_back(64'h00000000_00012340);
    @(negedge clk);
    idle();
    bus.ex_valid     = 1'b1;
    bus.id_ex_alu_op = 2'b10;
    bus.id_ex_instr  = {26'h0, 6'h20};
    bus.reg1         = 32'h1;
    bus.reg2         = 32'h2;
    #1;
    chk("busy_add_stall", bus.stall, 0);
    chk("busy_add_res", bus.alu_result, 32'h3);
    @(negedge clk);
    idle();
    @(negedge clk);
    bus.ex_valid     = 1'b1;
    bus.id_ex_alu_op = 2'b10;
    bus.id_ex_instr  = {26'h0, 6'h12};
    #1;
    chk("mflo_stall", bus.stall, 1);
    n = 0;
    while (bus.stall === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("mflo_stall_cycles", n, 30);
    chk("mflo_busy", bus.md_busy, 0);
    e = sb_q.pop_front();
    chk("mflo_val", bus.alu_result, e[31:0]);
    chk("mflo_hilo", {bus.hi_out, bus.lo_out}, e);
    @(negedge clk);
    idle();

    // Reset aborts a running MULT at BUSY cycle 10.
    @(negedge clk);
    drive_md(6'h18, 32'd5, 32'd9);
    @(negedge clk);
    idle();
    repeat (9) @(negedge clk);
    chk("abort_busy_pre", bus.md_busy, 1);
    reset     = 1'b1;
    bus.reg1  = 32'd20;
    bus.reg2  = 32'd22;
    #1 chk("rst_comb", bus.alu_result, 32'd42);
    @(negedge clk);
    reset            = 1'b0;
    bus.ex_valid     = 1'b1;
    bus.id_ex_alu_op = 2'b10;
    bus.id_ex_instr  = {26'h0, 6'h12};
    #1;
    chk("abort_busy", bus.md_busy, 0);
    chk("abort_stall", bus.stall, 0);
    chk("abort_hi", bus.hi_out, 0);
    chk("abort_lo", bus.lo_out, 0);
    @(negedge clk);
    idle();
    md_op("mult67", 6'h18, 32'd6, 32'd7, 64'd42);

`ifdef EX_MD_DIV_EN
    md_op("div", 6'h1A, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
    md_op("divu0", 6'h1B, 32'd7, 32'd0, 64'h00000007_FFFFFFFF);
    md_op("div_ovf", 6'h1A, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    md_op("div0s", 6'h1A, 32'hFFFFFFFB, 32'd0, 64'hFFFFFFFB_FFFFFFFF);
    md_op("divu", 6'h1B, 32'd100, 32'd7, 64'h00000002_0000000E);
`else
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive_md(k == 0 ? 6'h1A : 6'h1B, 32'd10, 32'd2);
      #1;
      chk("nodiv_stall", bus.stall, 0);
      chk("nodiv_res", bus.alu_result, 0);
      @(negedge clk);
      idle();
      chk("nodiv_busy", bus.md_busy, 0);
      repeat (2) @(negedge clk);
      chk("nodiv_hilo", {bus.hi_out, bus.lo_out}, 64'd42);
    end
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
